// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared constants for the CPU I/O bridge.
//   - I/O page tag and register word offsets within that page
//   - hex7(): hex nibble to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}
package io_bridge_pkg;

  localparam logic [19:0] IO_PAGE   = 20'hFFFFF;

  localparam logic [11:0] OFF_DISP  = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // Segment patterns are active-low; bit 7 (dp) is always 1 so the dot stays dark.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_bridge_seg_scanner.sv
// seg_scanner: time-multiplexes the 8-digit seven-segment display.
//   cpu_clk, cpu_rst (async, active-high)
//   disp[31:0]   : eight hex nibbles, nibble i drives digit i
//   dig_en[7:0]  : active-low one-hot digit enable
//   dig_seg[7:0] : active-low segments {dp,g,f,e,d,c,b,a}
// Each digit stays lit for SCAN_DIV cycles. Outputs are decoded from the
// registered digit index and the live disp value, so a DISP write shows up
// the cycle after it commits.
module seg_scanner
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] disp,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int            CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q,  dig_idx_d;

  // Next-state: count to TERM, then wrap and step to the next digit (7 wraps to 0).
  always_comb begin
    if (scan_cnt_q == TERM) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + CW'(1);
      dig_idx_d  = dig_idx_q;
    end
  end

  // Scan state registers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= 3'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
    end
  end

  // Digit select and segment decode of the selected nibble.
  always_comb begin
    dig_en  = ~(8'h01 << dig_idx_q);
    dig_seg = hex7(disp[{dig_idx_q, 2'b00} +: 4]);
  end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: data-bus responder between the single-cycle CPU and the board.
//   cpu_clk, cpu_rst (async, active-high)
//   Bus_addr/Bus_wen/Bus_wdata in, Bus_rdata out (combinational read)
//   dram_addr/dram_wen/dram_wdata out, dram_rdata in (DRAM pass-through)
//   sw[23:0], button[4:0] : raw asynchronous inputs, 2-flop synchronised
//   led[23:0]             : LED register
//   dig_en, dig_seg       : seven-segment display from seg_scanner
// Addresses with [31:12] == FFFFF hit the I/O page; all others go to DRAM.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic        io_sel;
  logic [11:0] io_off;
  logic        wr_disp, wr_timer, wr_led;
  logic        unused_addr_lsb;

  logic [31:0] disp_q,  disp_d;
  logic [31:0] timer_q, timer_d;
  logic [23:0] led_q,   led_d;
  logic [23:0] sw_meta_q,  sw_sync_q;
  logic [4:0]  btn_meta_q, btn_sync_q;

  // Byte lanes are unused: the bus is word-aligned.
  assign unused_addr_lsb = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;

  // Address decode and per-register write strobes.
  always_comb begin
    io_sel   = (Bus_addr[31:12] == IO_PAGE);
    io_off   = Bus_addr[11:0];
    dram_wen = Bus_wen & ~io_sel;
    wr_disp  = Bus_wen & io_sel & (io_off == OFF_DISP);
    wr_timer = Bus_wen & io_sel & (io_off == OFF_TIMER);
    wr_led   = Bus_wen & io_sel & (io_off == OFF_LED);
  end

  // Register next-state; a TIMER write takes priority over the increment.
  always_comb begin
    disp_d  = wr_disp  ? Bus_wdata        : disp_q;
    led_d   = wr_led   ? Bus_wdata[23:0]  : led_q;
    timer_d = wr_timer ? Bus_wdata        : timer_q + 32'd1;
  end

  // Bridge registers and the two-stage input synchronisers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      disp_q     <= 32'h0;
      timer_q    <= 32'h0;
      led_q      <= 24'h0;
      sw_meta_q  <= 24'h0;
      sw_sync_q  <= 24'h0;
      btn_meta_q <= 5'h0;
      btn_sync_q <= 5'h0;
    end else begin
      disp_q     <= disp_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Read mux: DRAM data outside the I/O page, register data inside; holes read 0.
  always_comb begin
    Bus_rdata = 32'h0;
    if (io_sel) begin
      case (io_off)
        OFF_DISP:  Bus_rdata = disp_q;
        OFF_TIMER: Bus_rdata = timer_q;
        OFF_LED:   Bus_rdata = {8'h00, led_q};
        OFF_SW:    Bus_rdata = {8'h00, sw_sync_q};
        OFF_BTN:   Bus_rdata = {27'h0, btn_sync_q};
        default:   Bus_rdata = 32'h0;
      endcase
    end else begin
      Bus_rdata = dram_rdata;
    end
  end

  assign led = led_q;

  seg_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scanner (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .disp    (disp_q),
    .dig_en  (dig_en),
    .dig_seg (dig_seg)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge (SCAN_DIV=4). Expected values are pushed
// onto a scoreboard queue when stimulus is applied and popped when the DUT
// output is sampled (#1 after the rising edge or after an input change).
module tb_io_bridge;

  localparam int SCAN_DIV = 4;
  localparam int DRAM_AW  = 14;

  localparam logic [31:0] A_DISP  = 32'hFFFFF000;
  localparam logic [31:0] A_TIMER = 32'hFFFFF020;
  localparam logic [31:0] A_LED   = 32'hFFFFF060;
  localparam logic [31:0] A_SW    = 32'hFFFFF070;
  localparam logic [31:0] A_BTN   = 32'hFFFFF078;
  localparam logic [31:0] A_HOLE  = 32'hFFFFF100;

  logic               cpu_clk = 1'b0;
  logic               cpu_rst;
  logic [31:0]        Bus_addr;
  logic               Bus_wen;
  logic [31:0]        Bus_wdata;
  logic [31:0]        Bus_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_wen;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata;
  logic [23:0]        sw;
  logic [4:0]         button;
  logic [23:0]        led;
  logic [7:0]         dig_en;
  logic [7:0]         dig_seg;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  io_bridge #(.SCAN_DIV(SCAN_DIV), .DRAM_AW(DRAM_AW)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .Bus_addr   (Bus_addr),
    .Bus_wen    (Bus_wen),
    .Bus_wdata  (Bus_wdata),
    .Bus_rdata  (Bus_rdata),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .button     (button),
    .led        (led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic sb_push(input string nm, input logic [31:0] v);
    exp_t x;
    x.nm = nm;
    x.v  = v;
    sb.push_back(x);
  endtask

  // Reset pulse that releases mid-cycle: the cycle after release is "cycle 0".
  task automatic pulse_reset();
    tick();
    cpu_rst = 1'b1;
    #2;
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset();
    Bus_addr = A_TIMER; Bus_wen = 1'b0;
    #2;
    sb_push("rst_timer", 32'h0);
    sb_push("rst_outs", {8'h00, 8'hFE, 8'hC0, 8'h00});
    sb_push("rst_led", 32'h0);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    e = sb.pop_front(); total++;
    if ({8'h00, dig_en, dig_seg, 8'h00} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, dig_en, dig_seg, 8'h00}, e.v); end
    e = sb.pop_front(); total++;
    if ({8'h00, led} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, led}, e.v); end
    // DRAM write strobe still follows Bus_wen while reset is held.
    Bus_addr = 32'h00000200; Bus_wen = 1'b1;
    #1;
    sb_push("rst_dram_wen", 32'h1);
    e = sb.pop_front(); total++;
    if ({31'h0, dram_wen} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_wen, e.v); end
    // Clock edges under reset must not advance the timer.
    Bus_wen = 1'b0; Bus_addr = A_TIMER;
    tick(); tick();
    sb_push("rst_hold_timer", 32'h0);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    cpu_rst = 1'b0;
  endtask

  task automatic test_dram();
    Bus_addr = 32'h00000104; Bus_wen = 1'b1; Bus_wdata = 32'hDEADBEEF;
    #1;
    sb_push("dram_addr", 32'h41);
    sb_push("dram_wen", 32'h1);
    sb_push("dram_wdata", 32'hDEADBEEF);
    e = sb.pop_front(); total++;
    if ({18'h0, dram_addr} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_addr, e.v); end
    e = sb.pop_front(); total++;
    if ({31'h0, dram_wen} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_wen, e.v); end
    e = sb.pop_front(); total++;
    if (dram_wdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_wdata, e.v); end
    tick();
    Bus_wen = 1'b0; dram_rdata = 32'h12345678;
    #1;
    sb_push("dram_read", 32'h12345678);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    // Just below the I/O page is still DRAM.
    Bus_addr = 32'hFFFFE000; dram_rdata = 32'hCAFE0001;
    #1;
    sb_push("dram_edge_read", 32'hCAFE0001);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
  endtask

  task automatic test_led();
    Bus_addr = A_LED; Bus_wen = 1'b1; Bus_wdata = 32'hFFA5A5A5;
    #1;
    sb_push("led_io_dram_wen", 32'h0);
    e = sb.pop_front(); total++;
    if ({31'h0, dram_wen} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_wen, e.v); end
    sb_push("led_pin", 32'h00A5A5A5);
    sb_push("led_read", 32'h00A5A5A5);
    tick();
    Bus_wen = 1'b0;
    #1;
    e = sb.pop_front(); total++;
    if ({8'h00, led} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, led}, e.v); end
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    // Unmapped offset: no DRAM strobe, reads 0, and no register changes.
    Bus_addr = A_HOLE; Bus_wen = 1'b1; Bus_wdata = 32'h12345678;
    #1;
    sb_push("hole_dram_wen", 32'h0);
    sb_push("hole_read", 32'h0);
    e = sb.pop_front(); total++;
    if ({31'h0, dram_wen} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, dram_wen, e.v); end
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    tick();
    // Write to the read-only SW register is ignored as well.
    Bus_addr = A_SW; Bus_wdata = 32'h00FFFFFF;
    tick();
    Bus_wen = 1'b0;
    sb_push("hole_led_kept", 32'h00A5A5A5);
    sb_push("ro_sw_kept", 32'h0);
    sb_push("hole_disp_kept", 32'h0);
    #1;
    e = sb.pop_front(); total++;
    if ({8'h00, led} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, led}, e.v); end
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    Bus_addr = A_DISP;
    #1;
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
  endtask

  task automatic test_switches();
    tick();
    sw = 24'h00F00F; button = 5'h15;
    sb_push("sw_edge0", 32'h0);
    sb_push("btn_edge0", 32'h0);
    sb_push("sw_edge1", 32'h0);
    sb_push("btn_edge1", 32'h0);
    sb_push("sw_edge2", 32'h0000F00F);
    sb_push("btn_edge2", 32'h00000015);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      Bus_addr = A_SW;
      #1;
      e = sb.pop_front(); total++;
      if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
      Bus_addr = A_BTN;
      #1;
      e = sb.pop_front(); total++;
      if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    end
  endtask

  task automatic test_timer();
    Bus_addr = A_TIMER; Bus_wen = 1'b0;
    pulse_reset();
    for (int k = 0; k < 10; k++) tick();
    sb_push("timer_10", 32'd10);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    Bus_wen = 1'b1; Bus_wdata = 32'hFFFFFFFE;
    #1;
    sb_push("timer_same_cycle_old", 32'd10);
    sb_push("timer_loaded", 32'hFFFFFFFE);
    sb_push("timer_max", 32'hFFFFFFFF);
    sb_push("timer_wrap", 32'h0);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    for (int k = 0; k < 3; k++) begin
      tick();
      Bus_wen = 1'b0;
      #1;
      e = sb.pop_front(); total++;
      if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    end
  endtask

  task automatic test_scan();
    Bus_wen = 1'b0;
    pulse_reset();
    Bus_addr = A_DISP; Bus_wen = 1'b1; Bus_wdata = 32'h76543210;
    // Digit i holds for SCAN_DIV cycles; nibble i of the pattern is i.
    for (int k = 0; k <= 8 * SCAN_DIV; k++) begin
      int idx;
      idx = (k / SCAN_DIV) % 8;
      sb_push($sformatf("scan_c%0d", k), {16'h0, ~(8'h01 << idx), seg_tbl[idx]});
    end
    for (int k = 0; k <= 8 * SCAN_DIV; k++) begin
      if (k != 0) tick();
      if (k == 1) Bus_wen = 1'b0;
      #1;
      e = sb.pop_front(); total++;
      if ({16'h0, dig_en, dig_seg} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {16'h0, dig_en, dig_seg}, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    Bus_wen = 1'b0;
    pulse_reset();
    Bus_addr = A_DISP;  Bus_wen = 1'b1; Bus_wdata = 32'h76543210;
    tick();
    Bus_addr = A_LED;   Bus_wdata = 32'h00123456;
    tick();
    Bus_addr = A_TIMER; Bus_wdata = 32'd499;
    tick();
    Bus_wen = 1'b0;
    tick();
    #1;
    sb_push("mid_timer_500", 32'd500);
    sb_push("mid_digit1", {16'h0, 8'hFD, 8'hF9});
    sb_push("mid_led", 32'h00123456);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    e = sb.pop_front(); total++;
    if ({16'h0, dig_en, dig_seg} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {16'h0, dig_en, dig_seg}, e.v); end
    e = sb.pop_front(); total++;
    if ({8'h00, led} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, led}, e.v); end
    // Assert reset between edges: everything must clear without a clock.
    cpu_rst = 1'b1;
    #1;
    sb_push("mid_rst_timer", 32'h0);
    sb_push("mid_rst_outs", {16'h0, 8'hFE, 8'hC0});
    sb_push("mid_rst_led", 32'h0);
    sb_push("mid_rst_disp", 32'h0);
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    e = sb.pop_front(); total++;
    if ({16'h0, dig_en, dig_seg} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {16'h0, dig_en, dig_seg}, e.v); end
    e = sb.pop_front(); total++;
    if ({8'h00, led} !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, {8'h00, led}, e.v); end
    Bus_addr = A_DISP;
    #1;
    e = sb.pop_front(); total++;
    if (Bus_rdata !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.nm, Bus_rdata, e.v); end
    #1;
    cpu_rst = 1'b0;
  endtask

  initial begin
    cpu_rst    = 1'b1;
    Bus_addr   = 32'h0;
    Bus_wen    = 1'b0;
    Bus_wdata  = 32'h0;
    dram_rdata = 32'h0;
    sw         = 24'h0;
    button     = 5'h0;
    test_reset();
    test_dram();
    test_led();
    test_switches();
    test_timer();
    test_scan();
    test_reset_mid();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
